// File: rtl/sorting_ctrl.sv
// Sequencing controller for the sorter: loads one frame of N words, waits for
// the sorter to settle, snapshots its parallel outputs and replays them as a stream.
module sorting_ctrl #(
    parameter int W        = 32,
    parameter int N        = 16,
    parameter int SORT_LAT = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           sorter_rst,
    output logic           sorter_en,
    output logic [W-1:0]   sorter_data,
    input  logic [N*W-1:0] sorted_bus,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_last,
    output logic           busy,
    output logic           done
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(SORT_LAT) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
    localparam logic [TW-1:0] WT_LAST  = TW'(SORT_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DRAIN} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  ld_cnt_q, ld_cnt_d;
    logic [CW-1:0]  rd_idx_q, rd_idx_d;
    logic [TW-1:0]  wt_cnt_q, wt_cnt_d;
    logic [N*W-1:0] snap_q, snap_d;
    logic           sorter_rst_q, sorter_rst_d;
    logic           sorter_en_q, sorter_en_d;
    logic [W-1:0]   sorter_data_q, sorter_data_d;
    logic           done_q, done_d;
    logic [W-1:0]   snap_slot [N];
    logic           in_fire;
    logic           out_fire;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            assign snap_slot[gi] = snap_q[gi*W +: W];
        end
    endgenerate

    // Input is held off during the clear cycle so the sorter never sees a word
    // in the same cycle it is being reset.
    assign in_ready    = (state_q == S_LOAD) && !sorter_rst_q;
    assign in_fire     = in_valid && in_ready;
    assign out_valid   = (state_q == S_DRAIN);
    assign out_fire    = out_valid && out_ready;
    assign out_data    = out_valid ? snap_slot[rd_idx_q] : '0;
    assign out_last    = out_valid && (rd_idx_q == LAST_IDX);
    assign busy        = (state_q != S_IDLE);
    assign sorter_rst  = sorter_rst_q;
    assign sorter_en   = sorter_en_q;
    assign sorter_data = sorter_data_q;
    assign done        = done_q;

    always_comb begin
        state_d       = state_q;
        ld_cnt_d      = ld_cnt_q;
        rd_idx_d      = rd_idx_q;
        wt_cnt_d      = wt_cnt_q;
        snap_d        = snap_q;
        sorter_rst_d  = 1'b0;
        sorter_en_d   = 1'b0;
        sorter_data_d = sorter_data_q;
        done_d        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    sorter_rst_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (in_fire) begin
                    sorter_en_d   = 1'b1;
                    sorter_data_d = in_data;
                    if (ld_cnt_q == LAST_IDX) begin
                        ld_cnt_d = '0;
                        wt_cnt_d = '0;
                        state_d  = S_WAIT;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Snapshot decouples the replay from the sorter being cleared
                // for the following frame.
                if (wt_cnt_q == WT_LAST) begin
                    snap_d   = sorted_bus;
                    rd_idx_d = '0;
                    wt_cnt_d = '0;
                    state_d  = S_DRAIN;
                end else begin
                    wt_cnt_d = wt_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (out_fire) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        done_d   = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            ld_cnt_q      <= '0;
            rd_idx_q      <= '0;
            wt_cnt_q      <= '0;
            snap_q        <= '0;
            sorter_rst_q  <= 1'b0;
            sorter_en_q   <= 1'b0;
            sorter_data_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ld_cnt_q      <= ld_cnt_d;
            rd_idx_q      <= rd_idx_d;
            wt_cnt_q      <= wt_cnt_d;
            snap_q        <= snap_d;
            sorter_rst_q  <= sorter_rst_d;
            sorter_en_q   <= sorter_en_d;
            sorter_data_q <= sorter_data_d;
            done_q        <= done_d;
        end
    end
endmodule

// File: doc/sorting_ctrl.md
# sorting_ctrl

Sequencing controller for the `sorting_top` sorter. It accepts a frame of N words from a valid/ready stream and clears the sorter before the frame. It feeds one word per `sorter_en` pulse, waits a fixed settle latency, snapshots the sorter's N parallel outputs, and replays them as a valid/ready stream with a last-word flag. It sits between the upstream data source and downstream consumers, owning the sorter's `en`, `rst` and `input_data` pins.

## Interface
- `W`, 32: data word width.
- `N`, 16: words per frame; equals the sorter's output count.
- `SORT_LAT`, 4: cycles (≥1) after the sorter samples the last word before `sorted_bus` is stable.

- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: frame request; sampled only in IDLE.
- `in_data` in W: upstream word.
- `in_valid` in 1: upstream word valid.
- `in_ready` out 1: controller accepts `in_data`.
- `sorter_rst` out 1: active-high clear to sorter.
- `sorter_en` out 1: one-cycle pulse per word fed.
- `sorter_data` out W: word to sorter `input_data`.
- `sorted_bus` in N*W: sorter outputs, slot k at `[k*W +: W]`, slot 0 = `sorted_data1`.
- `out_data` out W: replayed word.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: downstream accepts.
- `out_last` out 1: high with slot N-1.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse after final output handshake.

## Operation
- States: IDLE, LOAD, WAIT, DRAIN. Encoding is free.
- IDLE: `in_ready`=0, `out_valid`=0. If `start`=1, go to LOAD and register `sorter_rst`<=1.
- LOAD: `sorter_rst` is high only in the first LOAD cycle, then returns to 0. `in_ready` = (LOAD && !`sorter_rst`).
- LOAD handshake: on each `in_valid`&&`in_ready` edge, register `sorter_en`<=1 and `sorter_data`<=`in_data`, and increment `ld_cnt`. Otherwise `sorter_en`<=0.
- `sorter_data` holds its last value when idle.
- LOAD exit: on the Nth accept, `ld_cnt` clears and the state goes to WAIT with `wt_cnt`<=0.
- WAIT: `wt_cnt` increments each cycle. On the edge where `wt_cnt`==SORT_LAT-1, capture `snap`<=`sorted_bus`, go to DRAIN with `rd_idx`<=0.
- DRAIN: `out_valid`=1, `out_data`=`snap` slot `rd_idx`, `out_last`=(`rd_idx`==N-1).
- DRAIN advance: on `out_valid`&&`out_ready`, `rd_idx` increments. The handshake on slot N-1 returns the state to IDLE and pulses `done` next cycle.
- `out_data`/`out_valid` stay stable while `out_ready`=0.
- `start` outside IDLE is ignored. There is no abort; frames are always N words.
- Counter widths: `ld_cnt` and `rd_idx` are clog2(N) bits (N=16 → 4), `wt_cnt` is clog2(SORT_LAT)+1 bits. No wrap occurs: each counter is cleared at its terminal value.
- `snap` is held until the next WAIT exit, so it is unaffected by the sorter being cleared for the next frame.
- Reset (any state, including mid-LOAD/DRAIN): state=IDLE, all counters 0, `snap`=0. All outputs 0: `in_ready`, `sorter_rst`, `sorter_en`, `sorter_data`, `out_data`, `out_valid`, `out_last`, `busy`, `done`.
- The sorter is not cleared by this reset; the next frame's `sorter_rst` pulse clears it.

## Timing
- `start` sampled at edge E0: `sorter_rst`=1 and `busy`=1 in cycle E0..E1. `in_ready` first high in cycle E1..E2.
- Word accepted at edge Ek: `sorter_en`=1 with that word in cycle Ek..Ek+1, and the sorter samples it at Ek+1.
- With continuous `in_valid`, N words take N cycles; `sorter_en` is high N consecutive cycles.
- Nth accept at edge A: WAIT occupies SORT_LAT cycles, and `snap` is captured at edge A+SORT_LAT. The sorter's last sample is at A+1, so settle margin = SORT_LAT-1 cycles after that.
- First `out_valid` is in cycle A+SORT_LAT. With `out_ready`=1 throughout, N words stream in N cycles and `done` pulses at the edge after the last handshake.
- Minimum frame period with no back-pressure: 1 + N + SORT_LAT + N + 1 (IDLE→`start`) cycles.
- `in_valid` gaps stall LOAD. `out_ready` gaps stall DRAIN. No word is lost or duplicated.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `start`=1 and `in_valid`=1 → every output is 0 and the state stays IDLE. Release → `busy`=0 until `start`.
- Nominal frame with a behavioural sorter model: `start`, feed 16..1 continuously → `sorter_rst` pulses once, then `sorter_en` is high 16 cycles with `sorter_data`=16..1. The output stream is 1..16, `out_last` is set on 16, and `done` comes 1 cycle after.
- Back-pressure: `in_valid` toggling 1/0 and `out_ready` high every third cycle → `sorter_en` count = 16, output order unchanged, and `out_data` is stable while stalled.
- Latency: SORT_LAT=4 with a model whose outputs change 1 cycle before `snap` capture → the snapshot holds final values. First `out_valid` is exactly 4 cycles after the 16th accept.
- `start` asserted during LOAD/WAIT/DRAIN → no extra `sorter_rst` and the frame is unaffected. Back-to-back frames with 0x00000000 and 0xFFFFFFFF data → correct replay and no carry-over between frames.
- Reset asserted mid-DRAIN after 5 outputs → IDLE next cycle, `out_valid`=0. A new frame completes normally.
